// File: rtl/u_butterfly_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | u_butterfly_seq_if : control, twiddle, stream and count bundle           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface u_butterfly_seq_if #(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 4
);
  logic                            iStart;
  logic                            iEn;
  logic                            iInv;
  logic [BITWIDTH-1:0]             iwReal;
  logic [BITWIDTH-1:0]             iwImg;
  logic [LANES-1:0]                iReal0;
  logic [LANES-1:0]                iImg0;
  logic [LANES-1:0]                iReal1;
  logic [LANES-1:0]                iImg1;
  logic                            oBusy;
  logic                            oDone;
  logic [LANES-1:0]                oReal0;
  logic [LANES-1:0]                oImg0;
  logic [LANES-1:0]                oReal1;
  logic [LANES-1:0]                oImg1;
  logic [LANES*(BITWIDTH+1)-1:0]   oCntReal0;
  logic [LANES*(BITWIDTH+1)-1:0]   oCntImg0;
  logic [LANES*(BITWIDTH+1)-1:0]   oCntReal1;
  logic [LANES*(BITWIDTH+1)-1:0]   oCntImg1;

  modport master (
    output iStart, iEn, iInv, iwReal, iwImg, iReal0, iImg0, iReal1, iImg1,
    input  oBusy, oDone, oReal0, oImg0, oReal1, oImg1,
           oCntReal0, oCntImg0, oCntReal1, oCntImg1
  );

  modport slave (
    input  iStart, iEn, iInv, iwReal, iwImg, iReal0, iImg0, iReal1, iImg1,
    output oBusy, oDone, oReal0, oImg0, oReal1, oImg1,
           oCntReal0, oCntImg0, oCntReal1, oCntImg1
  );
endinterface
`default_nettype wire

// File: rtl/u_butterfly_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | u_butterfly_seq : self-sequenced multi-lane stochastic radix-2 butterfly |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module u_butterfly_seq #(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  u_butterfly_seq_if.slave  bus
);

  localparam int c_CNTW = BITWIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [BITWIDTH-1:0]          r_cnt;
  logic [BITWIDTH-1:0]          r_wReal;
  logic [BITWIDTH-1:0]          r_wImg;
  logic                         r_inv;
  logic                         r_done;
  logic [LANES-1:0][c_CNTW-1:0] r_cntR0;
  logic [LANES-1:0][c_CNTW-1:0] r_cntI0;
  logic [LANES-1:0][c_CNTW-1:0] r_cntR1;
  logic [LANES-1:0][c_CNTW-1:0] r_cntI1;

  logic                w_run;
  logic                w_start;
  logic                w_step;
  logic                w_last;
  logic [BITWIDTH-1:0] w_rev;
  logic                w_wr;
  logic                w_wi;
  logic [LANES-1:0]    w_r0;
  logic [LANES-1:0]    w_i0;
  logic [LANES-1:0]    w_r1;
  logic [LANES-1:0]    w_i1;

  assign w_run   = (r_state == S_RUN);
  assign w_start = bus.iStart && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_step  = w_run && bus.iEn;
  assign w_last  = w_step && (r_cnt == {BITWIDTH{1'b1}});

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.iStart) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.iStart) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Bit-reversed period counter spreads each twiddle's ones evenly over the period
  always_comb begin
    w_rev = '0;
    for (int b = 0; b < BITWIDTH; b++) begin
      w_rev[b] = r_cnt[BITWIDTH-1-b];
    end
  end

  assign w_wr = (w_rev < r_wReal);
  assign w_wi = (w_rev < r_wImg) ^ r_inv;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic w_pRR;
    logic w_pII;
    logic w_pRI;
    logic w_pIR;
    logic w_realEq;
    logic w_imgEq;

    assign w_pRR    = ~(bus.iReal1[k] ^ w_wr);
    assign w_pII    = ~(bus.iImg1[k]  ^ w_wi);
    assign w_pRI    = ~(bus.iReal1[k] ^ w_wi);
    assign w_pIR    = ~(bus.iImg1[k]  ^ w_wr);
    assign w_realEq = r_cnt[1] ? ~w_pII : w_pRR;
    assign w_imgEq  = r_cnt[1] ? w_pIR  : w_pRI;
    assign w_r0[k]  = r_cnt[0] ? w_realEq  : bus.iReal0[k];
    assign w_i0[k]  = r_cnt[0] ? w_imgEq   : bus.iImg0[k];
    assign w_r1[k]  = r_cnt[0] ? ~w_realEq : bus.iReal0[k];
    assign w_i1[k]  = r_cnt[0] ? ~w_imgEq  : bus.iImg0[k];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cnt   <= '0;
      r_wReal <= '0;
      r_wImg  <= '0;
      r_inv   <= 1'b0;
      r_done  <= 1'b0;
      r_cntR0 <= '0;
      r_cntI0 <= '0;
      r_cntR1 <= '0;
      r_cntI1 <= '0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_cnt   <= '0;
        r_wReal <= bus.iwReal;
        r_wImg  <= bus.iwImg;
        r_inv   <= bus.iInv;
        r_cntR0 <= '0;
        r_cntI0 <= '0;
        r_cntR1 <= '0;
        r_cntI1 <= '0;
      end else if (w_step) begin
        // Counter wraps to 0 on the final bit of the period
        r_cnt <= r_cnt + 1'b1;
        for (int k = 0; k < LANES; k++) begin
          r_cntR0[k] <= r_cntR0[k] + {{BITWIDTH{1'b0}}, w_r0[k]};
          r_cntI0[k] <= r_cntI0[k] + {{BITWIDTH{1'b0}}, w_i0[k]};
          r_cntR1[k] <= r_cntR1[k] + {{BITWIDTH{1'b0}}, w_r1[k]};
          r_cntI1[k] <= r_cntI1[k] + {{BITWIDTH{1'b0}}, w_i1[k]};
        end
      end
    end
  end

  assign bus.oBusy     = (r_state == S_LOAD) || w_run;
  assign bus.oDone     = r_done;
  assign bus.oReal0    = w_run ? w_r0 : '0;
  assign bus.oImg0     = w_run ? w_i0 : '0;
  assign bus.oReal1    = w_run ? w_r1 : '0;
  assign bus.oImg1     = w_run ? w_i1 : '0;
  assign bus.oCntReal0 = r_cntR0;
  assign bus.oCntImg0  = r_cntI0;
  assign bus.oCntReal1 = r_cntR1;
  assign bus.oCntImg1  = r_cntI1;

endmodule
`default_nettype wire

// File: tb/tb_u_butterfly_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_u_butterfly_seq : bench for u_butterfly_seq against a bipolar model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_u_butterfly_seq;

  localparam int BW = 8;
  localparam int LN = 4;
  localparam int N  = 1 << BW;
  localparam int CW = BW + 1;

  logic iClk = 1'b0;
  logic iRst;

  always #5 iClk = ~iClk;

  u_butterfly_seq_if #(.BITWIDTH(BW), .LANES(LN)) bus ();

  u_butterfly_seq #(.BITWIDTH(BW), .LANES(LN)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt [4][LN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_cnt(input int which, input int lane);
    case (which)
      0:       return 32'(bus.oCntReal0[lane*CW +: CW]);
      1:       return 32'(bus.oCntImg0[lane*CW +: CW]);
      2:       return 32'(bus.oCntReal1[lane*CW +: CW]);
      default: return 32'(bus.oCntImg1[lane*CW +: CW]);
    endcase
  endfunction

  // Bipolar multiply is XNOR; even phases pass X0, odd phases emit +/- W*X1 terms
  function automatic logic [3:0] ref_bits(input int c, input logic r0, input logic i0,
                                          input logic r1, input logic i1,
                                          input int wre, input int wim, input logic inv);
    int   rev;
    logic wr, wi, re, im;
    rev = 0;
    for (int b = 0; b < BW; b++) if (((c >> b) & 1) == 1) rev += 1 << (BW - 1 - b);
    wr = (rev < wre);
    wi = (rev < wim) ^ inv;
    case (c % 4)
      1:       begin re = (r1 == wr); im = (r1 == wi); end
      3:       begin re = (i1 != wi); im = (i1 == wr); end
      default: return {r0, i0, r0, i0};
    endcase
    return {re, im, !re, !im};
  endfunction

  task automatic set_lanes(input int mode, input logic [LN-1:0] mask);
    if (mode == 0) begin
      bus.iReal0 = mask; bus.iImg0 = mask; bus.iReal1 = mask; bus.iImg1 = mask;
    end else begin
      bus.iReal0 = LN'($urandom); bus.iImg0 = LN'($urandom);
      bus.iReal1 = LN'($urandom); bus.iImg1 = LN'($urandom);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, bus.oBusy, 0);
    check({tag, "_done"}, bus.oDone, 0);
    check({tag, "_streams"}, {bus.oReal0, bus.oImg0, bus.oReal1, bus.oImg1}, 0);
    for (int k = 0; k < LN; k++)
      for (int j = 0; j < 4; j++) check({tag, "_cnt"}, get_cnt(j, k), 0);
  endtask

  task automatic do_run(input int wre, input int wim, input logic inv,
                        input int in_mode, input logic [LN-1:0] mask,
                        input int stall_mode, input int abort_at, input bit disturb);
    int          c, guard;
    logic        en;
    logic [3:0]  b;
    logic [LN-1:0] er0, ei0, er1, ei1;
    bus.iStart = 1'b1; bus.iwReal = BW'(wre); bus.iwImg = BW'(wim); bus.iInv = inv;
    bus.iEn = 1'b1; set_lanes(in_mode, mask);
    @(negedge iClk);
    bus.iStart = disturb;
    check("load_busy", bus.oBusy, 1);
    check("load_done", bus.oDone, 0);
    check("load_streams", {bus.oReal0, bus.oImg0, bus.oReal1, bus.oImg1}, 0);
    for (int k = 0; k < LN; k++) begin
      check("load_cnt_r0", get_cnt(0, k), 0);
      check("load_cnt_i1", get_cnt(3, k), 0);
      for (int j = 0; j < 4; j++) exp_cnt[j][k] = 0;
    end
    @(negedge iClk);
    c = 0; guard = 0;
    while (c < N && guard < 4 * N) begin
      guard++;
      if (c == abort_at) begin
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        check_quiet("abort");
        @(negedge iClk);
        check("abort_stay_idle", bus.oBusy, 0);
        return;
      end
      case (stall_mode)
        1:       en = (guard % 3) != 0;
        2:       en = $urandom_range(3) != 0;
        default: en = 1'b1;
      endcase
      bus.iEn = en;
      set_lanes(in_mode, mask);
      if (disturb && c == 50) begin
        bus.iStart = 1'b1; bus.iwReal = BW'(~wre); bus.iwImg = BW'(wre); bus.iInv = ~inv;
      end else begin
        bus.iStart = 1'b0;
      end
      #1;
      for (int k = 0; k < LN; k++) begin
        b = ref_bits(c, bus.iReal0[k], bus.iImg0[k], bus.iReal1[k], bus.iImg1[k], wre, wim, inv);
        {er0[k], ei0[k], er1[k], ei1[k]} = b;
        if (en) begin
          exp_cnt[0][k] += int'(b[3]); exp_cnt[1][k] += int'(b[2]);
          exp_cnt[2][k] += int'(b[1]); exp_cnt[3][k] += int'(b[0]);
        end
      end
      check("run_streams", {bus.oReal0, bus.oImg0, bus.oReal1, bus.oImg1}, {er0, ei0, er1, ei1});
      check("run_busy", bus.oBusy, 1);
      check("run_done", bus.oDone, 0);
      if (en) c++;
      @(negedge iClk);
    end
    if (c < N) check("run_timeout", 0, 1);
    bus.iStart = 1'b0; bus.iEn = 1'b1;
    check("done_pulse", bus.oDone, 1);
    check("done_busy", bus.oBusy, 0);
    check("done_streams", {bus.oReal0, bus.oImg0, bus.oReal1, bus.oImg1}, 0);
    for (int k = 0; k < LN; k++)
      for (int j = 0; j < 4; j++) check("done_cnt", get_cnt(j, k), 32'(exp_cnt[j][k]));
    @(negedge iClk);
    check("done_one_cycle", bus.oDone, 0);
    for (int k = 0; k < LN; k++) check("done_hold_r0", get_cnt(0, k), 32'(exp_cnt[0][k]));
  endtask

  task automatic check_lane(input string tag, input int k, input int r0, input int i0,
                            input int r1, input int i1);
    check({tag, "_r0"}, get_cnt(0, k), 32'(r0));
    check({tag, "_i0"}, get_cnt(1, k), 32'(i0));
    check({tag, "_r1"}, get_cnt(2, k), 32'(r1));
    check({tag, "_i1"}, get_cnt(3, k), 32'(i1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRst = 1'b1;
    bus.iStart = 1'b0; bus.iEn = 1'b0; bus.iInv = 1'b0;
    bus.iwReal = '0; bus.iwImg = '0;
    set_lanes(0, '0);
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    check_quiet("reset");

    do_run(0, 0, 1'b0, 0, '1, 0, -1, 1'b0);
    for (int k = 0; k < LN; k++) check_lane("fwd_w0", k, 192, 128, 192, 256);

    do_run(0, 0, 1'b1, 0, '1, 0, -1, 1'b0);
    for (int k = 0; k < LN; k++) check_lane("inv_w0", k, 128, 192, 256, 192);

    do_run(0, 0, 1'b0, 0, '1, 1, -1, 1'b0);
    for (int k = 0; k < LN; k++) check_lane("stall3", k, 192, 128, 192, 256);

    do_run(0, 0, 1'b0, 0, '1, 0, 100, 1'b0);
    do_run(0, 0, 1'b0, 0, '1, 0, -1, 1'b0);
    for (int k = 0; k < LN; k++) check_lane("after_abort", k, 192, 128, 192, 256);

    do_run(0, 0, 1'b0, 0, '1, 0, -1, 1'b1);
    for (int k = 0; k < LN; k++) check_lane("disturb", k, 192, 128, 192, 256);

    do_run(0, 0, 1'b0, 0, 4'b0101, 0, -1, 1'b0);
    check_lane("lane0_ones", 0, 192, 128, 192, 256);
    check_lane("lane1_zeros", 1, 64, 128, 64, 0);

    do_run(N - 1, N / 2, 1'b0, 1, '0, 2, -1, 1'b0);
    do_run(1, N - 1, 1'b1, 1, '0, 2, -1, 1'b0);
    for (int r = 0; r < 3; r++)
      do_run(int'($urandom_range(N - 1)), int'($urandom_range(N - 1)), 1'($urandom),
             1, '0, 2, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
